// File: rtl/mext_dispatch.sv
// rtl/mext_dispatch.sv - RV32M dispatcher: decodes funct3, drives mul/div sub-units, resolves divide corner cases locally
module mext_dispatch #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        stb_i,
    input  logic        cyc_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output logic [31:0] result_o,
    output logic        err_o,
    output logic        ack_o,
    output logic        mul_stb_o,
    output logic        mul_cyc_o,
    output logic [31:0] mul_op_1_o,
    output logic [31:0] mul_op_2_o,
    output logic        mul_op_1_is_signed_o,
    output logic        mul_op_2_is_signed_o,
    output logic        mul_result_upper_o,
    input  logic [31:0] mul_result_i,
    input  logic        mul_ack_i,
    output logic        div_stb_o,
    output logic        div_cyc_o,
    output logic [31:0] div_op_1_o,
    output logic [31:0] div_op_2_o,
    output logic        div_is_signed_o,
    output logic        div_result_rem_o,
    input  logic [31:0] div_result_i,
    input  logic        div_ack_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_WAIT,
        S_DIV_WAIT,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic        sync_ack;
    logic [15:0] cnt;
    logic        accept;
    logic        is_div;
    logic        div_by_zero;
    logic        div_ovf;
    logic        fast_path;
    logic [31:0] fast_result;
    logic        sub_ack;
    logic        sub_end;
    logic        waiting;
    logic [31:0] sub_result;

    assign accept      = (state == S_IDLE) && stb_i && cyc_i && !sync_ack;
    assign is_div      = funct3_i[2];
    assign div_by_zero = is_div && (rs2_i == 32'd0);
    assign div_ovf     = is_div && !funct3_i[0] && (rs1_i == 32'h8000_0000) && (rs2_i == 32'hFFFF_FFFF);
    assign fast_path   = div_by_zero || div_ovf;
    assign fast_result = div_by_zero ? (funct3_i[1] ? rs1_i : 32'hFFFF_FFFF)
                                     : (funct3_i[1] ? 32'd0 : 32'h8000_0000);
    // Only the strobed unit's ack is meaningful; a stray ack from the idle unit is ignored.
    assign sub_ack     = (mul_stb_o && mul_ack_i) || (div_stb_o && div_ack_i);
    assign sub_end     = sub_ack || (cnt == TIMEOUT_LAST);
    assign waiting     = (state == S_MUL_WAIT) || (state == S_DIV_WAIT);
    assign sub_result  = (state == S_MUL_WAIT) ? mul_result_i : div_result_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = fast_path ? S_DONE : (is_div ? S_DIV_WAIT : S_MUL_WAIT);
                end
            end
            S_MUL_WAIT, S_DIV_WAIT: begin
                if (sub_end) begin
                    state_nxt = S_IDLE;
                end else if (!cyc_i) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (sub_end) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ack_o = sync_ack && stb_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_ack             <= 1'b0;
            cnt                  <= 16'd0;
            result_o             <= 32'd0;
            err_o                <= 1'b0;
            mul_stb_o            <= 1'b0;
            mul_cyc_o            <= 1'b0;
            mul_op_1_o           <= 32'd0;
            mul_op_2_o           <= 32'd0;
            mul_op_1_is_signed_o <= 1'b0;
            mul_op_2_is_signed_o <= 1'b0;
            mul_result_upper_o   <= 1'b0;
            div_stb_o            <= 1'b0;
            div_cyc_o            <= 1'b0;
            div_op_1_o           <= 32'd0;
            div_op_2_o           <= 32'd0;
            div_is_signed_o      <= 1'b0;
            div_result_rem_o     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (sync_ack) begin
                        sync_ack <= stb_i;
                    end
                    if (accept) begin
                        mul_op_1_o           <= rs1_i;
                        mul_op_2_o           <= rs2_i;
                        mul_op_1_is_signed_o <= (funct3_i == 3'b001) || (funct3_i == 3'b010);
                        mul_op_2_is_signed_o <= (funct3_i == 3'b001);
                        mul_result_upper_o   <= (funct3_i[1:0] != 2'b00);
                        div_op_1_o           <= rs1_i;
                        div_op_2_o           <= rs2_i;
                        div_is_signed_o      <= !funct3_i[0];
                        div_result_rem_o     <= funct3_i[1];
                        cnt                  <= 16'd0;
                        if (fast_path) begin
                            result_o <= fast_result;
                            err_o    <= 1'b0;
                        end else if (is_div) begin
                            div_stb_o <= 1'b1;
                            div_cyc_o <= 1'b1;
                        end else begin
                            mul_stb_o <= 1'b1;
                            mul_cyc_o <= 1'b1;
                        end
                    end
                end
                S_MUL_WAIT, S_DIV_WAIT, S_DRAIN: begin
                    cnt <= cnt + 16'd1;
                    if (sub_end) begin
                        mul_stb_o <= 1'b0;
                        mul_cyc_o <= 1'b0;
                        div_stb_o <= 1'b0;
                        div_cyc_o <= 1'b0;
                        // An ack coinciding with a flush is discarded like any drained result.
                        if (waiting && cyc_i) begin
                            result_o <= sub_ack ? sub_result : 32'd0;
                            err_o    <= !sub_ack;
                            sync_ack <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    sync_ack <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mext_dispatch.sv
// tb/tb_mext_dispatch.sv - directed self-checking bench for mext_dispatch
module tb_mext_dispatch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] rs1 = 32'd0;
    logic [31:0] rs2 = 32'd0;
    logic [31:0] result;
    logic        err;
    logic        ack;
    logic        mul_stb, mul_cyc;
    logic [31:0] mul_op_1, mul_op_2;
    logic        mul_s1, mul_s2, mul_upper;
    logic [31:0] mul_result = 32'd0;
    logic        mul_ack = 1'b0;
    logic        div_stb, div_cyc;
    logic [31:0] div_op_1, div_op_2;
    logic        div_signed, div_rem;
    logic [31:0] div_result = 32'd0;
    logic        div_ack = 1'b0;

    int checks = 0;
    int failures = 0;

    mext_dispatch #(.TIMEOUT_CYCLES(40)) dut (
        .clk_i                (clk),
        .rst_n_i              (rst_n),
        .stb_i                (stb),
        .cyc_i                (cyc),
        .funct3_i             (funct3),
        .rs1_i                (rs1),
        .rs2_i                (rs2),
        .result_o             (result),
        .err_o                (err),
        .ack_o                (ack),
        .mul_stb_o            (mul_stb),
        .mul_cyc_o            (mul_cyc),
        .mul_op_1_o           (mul_op_1),
        .mul_op_2_o           (mul_op_2),
        .mul_op_1_is_signed_o (mul_s1),
        .mul_op_2_is_signed_o (mul_s2),
        .mul_result_upper_o   (mul_upper),
        .mul_result_i         (mul_result),
        .mul_ack_i            (mul_ack),
        .div_stb_o            (div_stb),
        .div_cyc_o            (div_cyc),
        .div_op_1_o           (div_op_1),
        .div_op_2_o           (div_op_2),
        .div_is_signed_o      (div_signed),
        .div_result_rem_o     (div_rem),
        .div_result_i         (div_result),
        .div_ack_i            (div_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        funct3 = f;
        rs1 = a;
        rs2 = b;
        stb = 1'b1;
        cyc = 1'b1;
        tick();
    endtask

    task automatic release_req;
        stb = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset;
        stb = 1'b1;
        cyc = 1'b1;
        tick();
        tick();
        checks++;
        if ({result, err, ack} !== 34'd0) begin
            failures++; $display("FAIL reset_result: got %h/%b/%b expected 0/0/0", result, err, ack);
        end
        checks++;
        if ({mul_stb, mul_cyc, div_stb, div_cyc} !== 4'd0) begin
            failures++; $display("FAIL reset_strobes: got %b expected 0000", {mul_stb, mul_cyc, div_stb, div_cyc});
        end
        checks++;
        if ({mul_op_1, mul_op_2, div_op_1, div_op_2, mul_s1, mul_s2, mul_upper, div_signed, div_rem} !== 133'd0) begin
            failures++; $display("FAIL reset_operands: got nonzero operand/flag outputs expected all 0");
        end
        stb = 1'b0;
        cyc = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_mulhsu;
        issue(3'b010, 32'hFFFF_FFFF, 32'h0000_0002);
        checks++;
        if ({mul_stb, mul_cyc, div_stb} !== 3'b110) begin
            failures++; $display("FAIL mulhsu_strobe: got %b expected 110", {mul_stb, mul_cyc, div_stb});
        end
        checks++;
        if ({mul_s1, mul_s2, mul_upper, mul_op_1, mul_op_2} !== {3'b101, 32'hFFFF_FFFF, 32'h2}) begin
            failures++; $display("FAIL mulhsu_bus: got %b%b%b %h %h expected 101 ffffffff 00000002",
                                 mul_s1, mul_s2, mul_upper, mul_op_1, mul_op_2);
        end
        tick();
        tick();
        checks++;
        if (ack !== 1'b0) begin
            failures++; $display("FAIL mulhsu_early_ack: got %b expected 0", ack);
        end
        mul_result = 32'hFFFF_FFFF;
        mul_ack = 1'b1;
        tick();
        mul_ack = 1'b0;
        checks++;
        if ({mul_stb, ack, err, result} !== {3'b010, 32'hFFFF_FFFF}) begin
            failures++; $display("FAIL mulhsu_done: got stb=%b ack=%b err=%b res=%h expected 0 1 0 ffffffff",
                                 mul_stb, ack, err, result);
        end
        stb = 1'b0;
        #1;
        checks++;
        if (ack !== 1'b0) begin
            failures++; $display("FAIL ack_follows_stb: got %b expected 0", ack);
        end
        tick();
        tick();
    endtask

    task automatic test_div_zero;
        issue(3'b101, 32'h1234, 32'd0);
        checks++;
        if ({div_stb, ack} !== 2'b00) begin
            failures++; $display("FAIL divu0_edge_n: got stb=%b ack=%b expected 0 0", div_stb, ack);
        end
        tick();
        checks++;
        if ({div_stb, ack, err, result} !== {3'b010, 32'hFFFF_FFFF}) begin
            failures++; $display("FAIL divu0_result: got stb=%b ack=%b err=%b res=%h expected 0 1 0 ffffffff",
                                 div_stb, ack, err, result);
        end
        release_req();
        issue(3'b110, 32'h1234, 32'd0);
        tick();
        checks++;
        if ({div_stb, ack, result} !== {2'b01, 32'h1234}) begin
            failures++; $display("FAIL rem0_result: got stb=%b ack=%b res=%h expected 0 1 00001234",
                                 div_stb, ack, result);
        end
        release_req();
    endtask

    task automatic test_timeout;
        int n;
        issue(3'b100, 32'd100, 32'd7);
        checks++;
        if ({div_stb, div_cyc, div_signed, div_rem, mul_stb} !== 5'b11100) begin
            failures++; $display("FAIL timeout_issue: got %b expected 11100",
                                 {div_stb, div_cyc, div_signed, div_rem, mul_stb});
        end
        n = 0;
        while (div_stb === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n != 40) begin
            failures++; $display("FAIL timeout_cycles: got %0d expected 40", n);
        end
        checks++;
        if ({result, err, ack} !== {32'd0, 2'b11}) begin
            failures++; $display("FAIL timeout_result: got res=%h err=%b ack=%b expected 0 1 1", result, err, ack);
        end
        release_req();
    endtask

    task automatic test_div_overflow;
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
        checks++;
        if ({div_stb, ack} !== 2'b00) begin
            failures++; $display("FAIL ovf_edge_n: got stb=%b ack=%b expected 0 0", div_stb, ack);
        end
        tick();
        checks++;
        if ({ack, err, result} !== {2'b10, 32'h8000_0000}) begin
            failures++; $display("FAIL ovf_div: got ack=%b err=%b res=%h expected 1 0 80000000", ack, err, result);
        end
        release_req();
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
        tick();
        checks++;
        if ({div_stb, ack, result} !== {2'b01, 32'd0}) begin
            failures++; $display("FAIL ovf_rem: got stb=%b ack=%b res=%h expected 0 1 0", div_stb, ack, result);
        end
        release_req();
        issue(3'b101, 32'h8000_0000, 32'hFFFF_FFFF);
        checks++;
        if ({div_stb, div_signed, div_rem} !== 3'b100) begin
            failures++; $display("FAIL divu_no_fastpath: got %b expected 100", {div_stb, div_signed, div_rem});
        end
        div_result = 32'd0;
        div_ack = 1'b1;
        tick();
        div_ack = 1'b0;
        checks++;
        if ({div_stb, ack, result} !== {2'b01, 32'd0}) begin
            failures++; $display("FAIL divu_result: got stb=%b ack=%b res=%h expected 0 1 0", div_stb, ack, result);
        end
        release_req();
    endtask

    task automatic test_flush;
        logic held;
        held = 1'b1;
        issue(3'b000, 32'd3, 32'd5);
        for (int k = 1; k <= 33; k++) begin
            tick();
            if (k == 3) cyc = 1'b0;
            if (mul_stb !== 1'b1 || ack !== 1'b0) held = 1'b0;
        end
        checks++;
        if (held !== 1'b1) begin
            failures++; $display("FAIL flush_hold: got held=%b expected 1", held);
        end
        mul_result = 32'd15;
        mul_ack = 1'b1;
        tick();
        mul_ack = 1'b0;
        checks++;
        if ({mul_stb, ack, err, result} !== {3'b000, 32'd0}) begin
            failures++; $display("FAIL flush_discard: got stb=%b ack=%b err=%b res=%h expected 0 0 0 0",
                                 mul_stb, ack, err, result);
        end
        funct3 = 3'b011;
        rs1 = 32'h8000_0000;
        rs2 = 32'd4;
        cyc = 1'b1;
        tick();
        checks++;
        if ({mul_stb, mul_s1, mul_s2, mul_upper, mul_op_1} !== {4'b1001, 32'h8000_0000}) begin
            failures++; $display("FAIL flush_next_accept: got stb=%b flags=%b%b%b op1=%h expected 1 001 80000000",
                                 mul_stb, mul_s1, mul_s2, mul_upper, mul_op_1);
        end
        mul_result = 32'd2;
        mul_ack = 1'b1;
        tick();
        mul_ack = 1'b0;
        checks++;
        if ({ack, result} !== {1'b1, 32'd2}) begin
            failures++; $display("FAIL mulhu_result: got ack=%b res=%h expected 1 00000002", ack, result);
        end
        release_req();
    endtask

    task automatic test_back_to_back;
        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checks++;
        if ({mul_s1, mul_s2, mul_upper} !== 3'b111) begin
            failures++; $display("FAIL mulh_flags: got %b expected 111", {mul_s1, mul_s2, mul_upper});
        end
        mul_result = 32'd0;
        mul_ack = 1'b1;
        tick();
        mul_ack = 1'b0;
        checks++;
        if ({ack, result} !== {1'b1, 32'd0}) begin
            failures++; $display("FAIL mulh_result: got ack=%b res=%h expected 1 0", ack, result);
        end
        funct3 = 3'b000;
        tick();
        checks++;
        if ({mul_stb, ack} !== 2'b01) begin
            failures++; $display("FAIL held_stb_no_accept: got stb=%b ack=%b expected 0 1", mul_stb, ack);
        end
        stb = 1'b0;
        tick();
        stb = 1'b1;
        tick();
        checks++;
        if ({mul_stb, mul_s1, mul_s2, mul_upper} !== 4'b1000) begin
            failures++; $display("FAIL b2b_accept: got %b expected 1000", {mul_stb, mul_s1, mul_s2, mul_upper});
        end
        mul_result = 32'd1;
        mul_ack = 1'b1;
        tick();
        mul_ack = 1'b0;
        checks++;
        if ({ack, result} !== {1'b1, 32'd1}) begin
            failures++; $display("FAIL b2b_result: got ack=%b res=%h expected 1 00000001", ack, result);
        end
        release_req();
    endtask

    task automatic test_reset_mid;
        issue(3'b000, 32'd7, 32'd6);
        tick();
        tick();
        rst_n = 1'b0;
        stb = 1'b0;
        #1;
        checks++;
        if ({mul_stb, mul_cyc, div_stb, div_cyc, ack, err, result, mul_op_1, mul_op_2} !== 102'd0) begin
            failures++; $display("FAIL async_reset: got stb=%b cyc=%b res=%h op1=%h expected all 0",
                                 mul_stb, mul_cyc, result, mul_op_1);
        end
        tick();
        rst_n = 1'b1;
        tick();
        issue(3'b000, 32'd7, 32'd6);
        checks++;
        if ({mul_stb, mul_s1, mul_s2, mul_upper, mul_op_1, mul_op_2} !== {4'b1000, 32'd7, 32'd6}) begin
            failures++; $display("FAIL post_reset_issue: got stb=%b op1=%h op2=%h expected 1 7 6",
                                 mul_stb, mul_op_1, mul_op_2);
        end
        mul_result = 32'd42;
        mul_ack = 1'b1;
        tick();
        mul_ack = 1'b0;
        checks++;
        if ({ack, err, result} !== {2'b10, 32'd42}) begin
            failures++; $display("FAIL post_reset_result: got ack=%b err=%b res=%h expected 1 0 0000002a",
                                 ack, err, result);
        end
        release_req();
    endtask

    initial begin
        test_reset();
        test_mulhsu();
        test_div_zero();
        test_timeout();
        test_div_overflow();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
